ternary_neuron_sign: RTL and testbench

- Sequential ternary multiply-accumulate neuron with built-in sign activation. It is the per-neuron compute engine of the layer-1 datapath.
- The parent controller drives one input and one weight per cycle, addressed by this block's own MAC counter. The block adds a bias, saturates the sum and presents a ternary activated output.
- One instance is reused for all neurons of a layer.

---
 rtl/ternary_neuron_sign_if.sv | 31 +++
 rtl/ternary_neuron_sign.sv | 113 +++++++++++
 tb/tb_ternary_neuron_sign.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ternary_neuron_sign_if.sv
// Handshake and data bundle between the layer controller and the ternary neuron.
//   start         : one-cycle pulse to begin a neuron computation
//   input_val     : ternary input for index mac_count_out (00=0, 01=+1, 11=-1, 10=0)
//   weight        : ternary weight for index mac_count_out
//   bias          : signed 4-bit bias, -8..+7
//   done          : one-cycle pulse, result valid
//   busy          : high from the cycle after start until done
//   result        : signed 7-bit saturated pre-activation sum
//   act_out       : ternary sign of result
//   mac_count_out : index of the input/weight pair consumed this cycle
interface ternary_neuron_sign_if;
  logic       start;
  logic [1:0] input_val;
  logic [1:0] weight;
  logic [3:0] bias;
  logic       done;
  logic       busy;
  logic [6:0] result;
  logic [1:0] act_out;
  logic [5:0] mac_count_out;

  modport master (
    output start, input_val, weight, bias,
    input  done, busy, result, act_out, mac_count_out
  );

  modport slave (
    input  start, input_val, weight, bias,
    output done, busy, result, act_out, mac_count_out
  );
endinterface

// File: rtl/ternary_neuron_sign.sv
// Sequential ternary multiply-accumulate neuron with sign activation.
// One input/weight pair is consumed per cycle at index mac_count_out; after
// N_INPUTS steps the bias is added, the sum is saturated to -64..+63 and
// held in result. act_out is the ternary sign of result.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any computation)
//   bus   : controller handshake/data bundle (slave side)
module ternary_neuron_sign #(
  parameter int unsigned N_INPUTS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ternary_neuron_sign_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    BIAS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(N_INPUTS - 1);

  state_t            state;
  logic [5:0]        count;
  // Worst case -64-8 .. +64+7 fits in 8 signed bits.
  logic signed [7:0] acc;
  logic signed [6:0] result_q;
  logic              done_q;
  logic              busy_q;

  logic signed [7:0] prod;
  logic signed [7:0] bias_ext;
  logic signed [7:0] acc_biased;
  logic signed [6:0] sat_val;

  // Bit 0 marks a non-zero ternary value and bit 1 its sign, so 2'b10
  // naturally decodes as zero.
  always_comb begin
    prod = '0;
    if (bus.input_val[0] && bus.weight[0]) begin
      prod = (bus.input_val[1] ^ bus.weight[1]) ? -8'sd1 : 8'sd1;
    end
  end

  always_comb begin
    bias_ext   = {{4{bus.bias[3]}}, bus.bias};
    acc_biased = acc + bias_ext;
    if (acc_biased > 8'sd63) begin
      sat_val = 7'sd63;
    end else if (acc_biased < -8'sd64) begin
      sat_val = -7'sd64;
    end else begin
      sat_val = acc_biased[6:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod;
          if (count == LAST_IDX) begin
            count <= '0;
            state <= BIAS;
          end else begin
            count <= count + 6'd1;
          end
        end
        BIAS: begin
          acc      <= acc_biased;
          result_q <= sat_val;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The parent indexes its ROM/pixels with this in the same cycle.
  assign bus.mac_count_out = (state == MAC) ? count : '0;
  assign bus.done          = done_q;
  assign bus.busy          = busy_q;
  assign bus.result        = result_q;
  assign bus.act_out       = result_q[6]  ? 2'b11 :
                             (|result_q)  ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ternary_neuron_sign.sv
// Self-checking bench for ternary_neuron_sign against a plain-arithmetic
// reference (dot product of decoded ternary values plus bias, clamped).
module tb_ternary_neuron_sign;
  localparam int N = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ternary_neuron_sign_if ifc ();

  ternary_neuron_sign #(.N_INPUTS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  logic [1:0] vin [N];
  logic [1:0] vw  [N];

  // Controller side: data follows the neuron's own index combinationally.
  assign ifc.input_val = vin[ifc.mac_count_out];
  assign ifc.weight    = vw[ifc.mac_count_out];

  int vectors    = 0;
  int miscompares = 0;
  int prev_exp   = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tval(input logic [1:0] v);
    case (v)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int model_result(input int b);
    int s;
    s = b;
    for (int i = 0; i < N; i++) s += tval(vin[i]) * tval(vw[i]);
    if (s > 63) s = 63;
    if (s < -64) s = -64;
    return s;
  endfunction

  function automatic int model_act(input int r);
    if (r > 0) return 1;
    if (r < 0) return 3;
    return 0;
  endfunction

  function automatic logic [1:0] rnd_t();
    return 2'($urandom_range(0, 3));
  endfunction

  // Entered and left on a negedge with the DUT idle. glitch_at / reset_at
  // give the MAC index at which to pulse start again or pull reset (-1: never).
  task automatic run(input int b, input int glitch_at, input int reset_at);
    int exp_r, k, dones, done_k;
    bit aborted;
    exp_r    = model_result(b);
    ifc.bias = 4'(b);
    ifc.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 0; dones = 0; done_k = -1; aborted = 1'b0;
    while (k < 200) begin
      if (k <= N - 1) begin
        check("mac_count", int'(ifc.mac_count_out), k);
        check("busy_mac", int'(ifc.busy), 1);
      end
      if (k == 10) check("result_held", int'($signed(ifc.result)), prev_exp);
      if (ifc.done) begin
        dones++;
        if (done_k < 0) done_k = k;
      end
      ifc.start = (k == glitch_at);
      if (k == reset_at) begin
        aborted = 1'b1;
        break;
      end
      if (done_k >= 0 && k == done_k + 1) break;
      @(negedge clk);
      k++;
    end
    ifc.start = 1'b0;
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      check("rst_result", int'($signed(ifc.result)), 0);
      check("rst_busy", int'(ifc.busy), 0);
      check("rst_done", int'(ifc.done), 0);
      check("rst_act", int'(ifc.act_out), 0);
      check("rst_mac", int'(ifc.mac_count_out), 0);
      prev_exp = 0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      check("done_latency", done_k, N + 1);
      check("done_pulses", dones, 1);
      check("result", int'($signed(ifc.result)), exp_r);
      check("act_out", int'(ifc.act_out), model_act(exp_r));
      check("busy_idle", int'(ifc.busy), 0);
      check("mac_idle", int'(ifc.mac_count_out), 0);
      prev_exp = exp_r;
    end
  endtask

  initial begin
    ifc.start = 1'b0;
    ifc.bias  = '0;
    for (int i = 0; i < N; i++) begin vin[i] = 2'b00; vw[i] = 2'b00; end
    repeat (2) @(negedge clk);
    check("reset_result", int'($signed(ifc.result)), 0);
    check("reset_done", int'(ifc.done), 0);
    check("reset_busy", int'(ifc.busy), 0);
    check("reset_mac", int'(ifc.mac_count_out), 0);
    check("reset_act", int'(ifc.act_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All +1 x +1: 64 saturates to +63.
    for (int i = 0; i < N; i++) begin vin[i] = 2'b01; vw[i] = 2'b01; end
    run(0, -1, -1);

    // All +1 x -1 with bias -8: -72 saturates to -64.
    for (int i = 0; i < N; i++) begin vin[i] = 2'b01; vw[i] = 2'b11; end
    run(-8, -1, -1);

    // Alternating weights cancel.
    for (int i = 0; i < N; i++) begin vin[i] = 2'b01; vw[i] = (i % 2 == 0) ? 2'b01 : 2'b11; end
    run(0, -1, -1);
    run(5, -1, -1);

    // Zero and reserved inputs contribute nothing.
    for (int i = 0; i < N; i++) begin vin[i] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00; vw[i] = 2'b01; end
    run(-3, -1, -1);

    // Start mid-computation ignored, then an immediate restart.
    for (int i = 0; i < N; i++) begin vin[i] = rnd_t(); vw[i] = rnd_t(); end
    run($urandom_range(0, 15) - 8, 20, -1);
    for (int i = 0; i < N; i++) begin vin[i] = rnd_t(); vw[i] = rnd_t(); end
    run($urandom_range(0, 15) - 8, -1, -1);

    // Abort by reset, then a full computation.
    run(3, -1, 30);
    for (int i = 0; i < N; i++) begin vin[i] = rnd_t(); vw[i] = rnd_t(); end
    run($urandom_range(0, 15) - 8, -1, -1);

    // Random runs; every other one correlates weights to inputs to reach the clamp.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        vin[i] = rnd_t();
        vw[i]  = (r % 2 == 1 && $urandom_range(0, 7) != 0) ? vin[i] : rnd_t();
      end
      run($urandom_range(0, 15) - 8, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
